// File: rtl/v10_pulse_generator.sv
// Detector-like pulse synthesiser: linear rise over 2^RISE_SHIFT cycles, exponential tail with tau = 2^DECAY_SHIFT.
// Optional V10_PULSE_NOISE_EN adds a small LFSR dither (-4..+3 counts) to every output sample.
module v10_pulse_generator #(
  parameter int SIZE_ADC_DATA = 12,
  parameter int DECAY_SHIFT   = 4,
  parameter int RISE_SHIFT    = 2,
  parameter int FRAC_BITS     = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     trig_valid,
  output logic                     trig_ready,
  input  logic [SIZE_ADC_DATA-1:0] trig_amplitude,
  input  logic [SIZE_ADC_DATA-1:0] baseline,
  output logic [SIZE_ADC_DATA-1:0] adc_data,
  output logic                     busy,
  output logic [15:0]              pulse_count
);
  localparam int PW  = SIZE_ADC_DATA + FRAC_BITS;
  localparam int SW  = SIZE_ADC_DATA + 2;
  localparam int RCW = (RISE_SHIFT > 0) ? RISE_SHIFT : 1;
  localparam logic [PW-1:0]  PMAX      = {PW{1'b1}} << FRAC_BITS;
  localparam logic [RCW-1:0] RISE_LAST = RCW'((1 << RISE_SHIFT) - 1);
  localparam logic [SW-1:0]  OUT_MAX   = SW'((1 << SIZE_ADC_DATA) - 1);

  typedef enum logic [1:0] {IDLE, RISE, DECAY} state_t;

  state_t                   state_q, state_d;
  logic [PW-1:0]            p_q, p_d;
  logic [PW-1:0]            target_q, target_d;
  logic [PW-1:0]            step_q, step_d;
  logic [RCW-1:0]           rise_cnt_q, rise_cnt_d;
  logic [SIZE_ADC_DATA-1:0] adc_q, adc_d;
  logic [15:0]              count_q, count_d;

  logic                     accept;
  logic [PW-1:0]            amp_fx, tgt, decay_amt, p_int;
  logic [PW:0]              sum_full;
  logic [SW-1:0]            base_sum, with_pos, out_sum;
  logic [2:0]               noise_pos, noise_neg;

  assign trig_ready  = reset & (state_q != RISE);
  assign busy        = (state_q != IDLE);
  assign adc_data    = adc_q;
  assign pulse_count = count_q;
  assign accept      = trig_valid & trig_ready;

`ifdef V10_PULSE_NOISE_EN
  logic [15:0] lfsr_q, lfsr_d;

  // lfsr[2:0] >= 4 maps to +0..+3, below 4 maps to -4..-1
  always_comb begin
    lfsr_d    = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    noise_pos = lfsr_q[2] ? {1'b0, lfsr_q[1:0]} : 3'd0;
    noise_neg = lfsr_q[2] ? 3'd0 : 3'd4 - lfsr_q[2:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) lfsr_q <= 16'hACE1;
    else        lfsr_q <= lfsr_d;
  end
`else
  assign noise_pos = '0;
  assign noise_neg = '0;
`endif

  always_comb begin
    amp_fx    = PW'(trig_amplitude) << FRAC_BITS;
    sum_full  = {1'b0, p_q} + {1'b0, amp_fx};
    tgt       = (sum_full > {1'b0, PMAX}) ? PMAX : sum_full[PW-1:0];
    decay_amt = p_q >> DECAY_SHIFT;
    // Tail must reach zero: the last few LSBs decay one per cycle
    if (decay_amt == '0 && p_q != '0) decay_amt = PW'(1);

    state_d    = state_q;
    p_d        = p_q;
    target_d   = target_q;
    step_d     = step_q;
    rise_cnt_d = rise_cnt_q;
    count_d    = count_q;

    case (state_q)
      RISE: begin
        if (rise_cnt_q == RISE_LAST) begin
          p_d     = target_q;
          state_d = DECAY;
        end else begin
          p_d        = p_q + step_q;
          rise_cnt_d = rise_cnt_q + RCW'(1);
        end
      end
      DECAY: begin
        if (!accept) begin
          if (p_q == '0) state_d = IDLE;
          else           p_d     = p_q - decay_amt;
        end
      end
      default: p_d = '0;
    endcase

    // Accept starts a rise from the current P (pile-up); P holds this edge
    if (accept) begin
      state_d    = RISE;
      p_d        = p_q;
      target_d   = tgt;
      step_d     = (tgt - p_q) >> RISE_SHIFT;
      rise_cnt_d = '0;
      count_d    = count_q + 16'd1;
    end

    p_int    = p_q >> FRAC_BITS;
    base_sum = SW'(baseline) + SW'(p_int);
    with_pos = base_sum + SW'(noise_pos);
    out_sum  = (with_pos < SW'(noise_neg)) ? '0 : with_pos - SW'(noise_neg);
    adc_d    = (out_sum > OUT_MAX) ? '1 : out_sum[SIZE_ADC_DATA-1:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      p_q        <= '0;
      target_q   <= '0;
      step_q     <= '0;
      rise_cnt_q <= '0;
      adc_q      <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      p_q        <= p_d;
      target_q   <= target_d;
      step_q     <= step_d;
      rise_cnt_q <= rise_cnt_d;
      adc_q      <= adc_d;
      count_q    <= count_d;
    end
  end
endmodule
